comm_master_mb: RTL
===================

Name: comm_master_mb

Overview:
Parametrised successor to the single-response CommMaster that drives the copter's wireless UART link from the bench or a ground-station FPGA.
- Serialises a frame of one command byte plus DATA_BYTES data bytes over 8N1 UART.
- Collects a RESP_BYTES-wide response.
- Flags a response timeout when the copter stays silent.
- Sits between the test sequencer and the DUT's RX/TX pins.

Parameters:
DATA_BYTES, 2, data bytes sent after the command byte (1..4)
RESP_BYTES, 1, response bytes collected per frame (1..4)
BAUD_DIV, 2604, clk cycles per UART bit (19200 baud at 50 MHz), minimum 8
TMO_CLKS, 2000000, clk cycles allowed from end of TX stop bit to the first response start bit (also the maximum gap between response bytes)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
snd_cmd  in  1  one-cycle request to send a frame; sampled only in IDLE
cmd  in  8  command opcode, latched on an accepted snd_cmd
data  in  8*DATA_BYTES  payload, latched on an accepted snd_cmd, sent MSB byte first
clr_resp_rdy  in  1  clears resp_rdy and resp_tmo
RX  in  1  serial input from the copter (asynchronous)
TX  out  1  serial output to the copter; idles high
frm_snt  out  1  set when the last TX stop bit ends; cleared on the next accepted snd_cmd
resp_rdy  out  1  set when all RESP_BYTES bytes have been received
resp  out  8*RESP_BYTES  response, first received byte in the MSB position
resp_tmo  out  1  set on timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: TX=1, frm_snt=0, resp_rdy=0, resp=0, resp_tmo=0, busy=0; FSM enters IDLE; all counters cleared.
- Asserting reset mid-frame aborts immediately and leaves TX high; no partial byte completes.
- FSM states: IDLE, LOAD, TX_BYTE, RESP_WAIT, DONE.
  - IDLE: snd_cmd=1 latches cmd and data into a (1+DATA_BYTES)-byte shift register, clears frm_snt, resp_rdy and resp_tmo, and moves to LOAD.
  - LOAD: fixed one-cycle state; loads the next byte into the TX serialiser, then moves to TX_BYTE.
  - TX_BYTE: sends start bit (0), 8 data bits LSB first, then stop bit (1), each exactly BAUD_DIV cycles.
    - At the end of a stop bit, go to LOAD if bytes remain.
    - Otherwise set frm_snt, clear the byte counter, and go to RESP_WAIT.
  - RESP_WAIT: each byte from the receiver shifts into resp.
    - After RESP_BYTES bytes: set resp_rdy in the same cycle as the last byte's valid, then go to DONE.
    - If the timeout counter reaches TMO_CLKS: set resp_tmo, leave resp holding any partial bytes, then go to DONE.
  - DONE: returns to IDLE on the next cycle.
- Latency: first start bit begins 2 cycles after snd_cmd. Frame length is (1+DATA_BYTES)*10*BAUD_DIV cycles.
- Timeout counter is 32 bits. It resets when RESP_WAIT is entered and on every received byte; it does not count during an RX byte in progress.
- snd_cmd outside IDLE is ignored with no side effects.
- clr_resp_rdy clears resp_rdy and resp_tmo but not resp. If clr_resp_rdy and set occur in the same cycle, set wins.
- Receiver:
  - RX passes through a two-flop synchroniser.
  - A start bit is detected on a falling edge, re-checked at BAUD_DIV/2 cycles, and rejected as a glitch if high.
  - Data bits are sampled at bit centres.
  - A stop bit sampled as 0 is a framing error: the byte is discarded and does not count.
  - The receiver is always running, but bytes completing outside RESP_WAIT are dropped.

Decomposition:
- Package comm_pkg: opcode localparams (REQ_BATT=8'h01 … MTRS_OFF=8'h08), the FSM state enum, and the ACK value 8'hA5.
- One sub-module, uart_rx_byte:
  - Contains the synchroniser, start-bit validation and bit sampling.
  - Outputs rx_byte[7:0] and rx_vld, a one-cycle pulse.
  - Parametrised by BAUD_DIV.
- The TX serialiser and frame FSM stay in the top module.

Test Plan:
- Defaults, BAUD_DIV=8: snd_cmd with cmd=8'h02, data=16'h1234 → TX carries bytes 02,12,34; frm_snt rises exactly 2+240 cycles after snd_cmd; busy=1 throughout.
- RESP_BYTES=2, model replies C0,7F → resp=16'hC07F, resp_rdy=1, resp_tmo=0; clr_resp_rdy → resp_rdy=0 with resp held.
- Model silent, TMO_CLKS=500 → resp_tmo=1 exactly 500 cycles after frm_snt, resp_rdy=0; FSM back in IDLE and accepts a new snd_cmd.
- Second snd_cmd pulsed mid-frame → ignored, frame bytes unchanged; an RX byte arriving during TX is dropped; a 2-cycle RX low glitch is not taken as a start bit.
- Reply with a bad stop bit then A5 (RESP_BYTES=1) → resp=8'hA5; rst pulsed mid TX_BYTE → TX=1 and all outputs at reset values the same cycle.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the copter command link: opcodes, the ACK byte
// and the frame FSM state type.
package comm_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] ACK = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StTxByte,
        StRespWait,
        StDone
    } comm_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, falling-edge start detect
// with a half-bit glitch re-check, centre sampling and stop-bit validation.
module uart_rx_byte #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_busy
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    byte_q, byte_d;
    logic          vld_q, vld_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    // Synchroniser, edge-detect history and receiver state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= RxIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            byte_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            byte_q    <= byte_d;
            vld_q     <= vld_d;
        end
    end

    // Bit timing: start re-checked mid-bit, data and stop sampled at centres.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        byte_d  = byte_q;
        vld_d   = 1'b0;
        unique case (state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s) begin
                    cnt_d   = '0;
                    state_d = RxStart;
                end
            end
            RxStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // Line back high at mid-start: treat as a glitch.
                    state_d = rx_s ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    sr_d  = {rx_s, sr_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RxStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                    // A low stop bit is a framing error; the byte is discarded.
                    if (rx_s) begin
                        byte_d = sr_q;
                        vld_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign rx_byte = byte_q;
    assign rx_vld  = vld_q;
    assign rx_busy = (state_q != RxIdle);

endmodule

// File: rtl/comm_master_mb.sv
// Command-link master: sends a command byte plus DATA_BYTES payload bytes
// over 8N1 UART, then collects RESP_BYTES response bytes or times out.
module comm_master_mb
    import comm_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 2,
    parameter int unsigned RESP_BYTES = 1,
    parameter int unsigned BAUD_DIV   = 2604,
    parameter int unsigned TMO_CLKS   = 2000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    snd_cmd,
    input  logic [7:0]              cmd,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    clr_resp_rdy,
    input  logic                    RX,
    output logic                    TX,
    output logic                    frm_snt,
    output logic                    resp_rdy,
    output logic [8*RESP_BYTES-1:0] resp,
    output logic                    resp_tmo,
    output logic                    busy
);

    localparam int unsigned NUM_BYTES = DATA_BYTES + 1;
    localparam int unsigned FW        = 8 * NUM_BYTES;
    localparam int unsigned RW        = 8 * RESP_BYTES;
    localparam int unsigned CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST    = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_PRELOAD = CW'(BAUD_DIV - 2);
    localparam logic [2:0]    BYTES_ALL   = 3'(NUM_BYTES);
    localparam logic [2:0]    RESP_LAST   = 3'(RESP_BYTES - 1);
    localparam logic [31:0]   TMO_LAST    = 32'(TMO_CLKS - 1);

    comm_state_e   state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [9:0]    tx_sr_q, tx_sr_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [2:0]    resp_cnt_q, resp_cnt_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [RW-1:0] resp_q, resp_d;
    logic          frm_snt_q, frm_snt_d;
    logic          resp_rdy_q, resp_rdy_d;
    logic          resp_tmo_q, resp_tmo_d;

    logic [7:0]    rx_byte;
    logic          rx_vld;
    logic          rx_busy;
    logic [RW+7:0] resp_ext;

    uart_rx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx     (RX),
        .rx_byte(rx_byte),
        .rx_vld (rx_vld),
        .rx_busy(rx_busy)
    );

    assign resp_ext = {resp_q, rx_byte};

    // Frame FSM, serialiser, response and timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            tx_sr_q    <= '1;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_cnt_q <= '0;
            resp_cnt_q <= '0;
            tmo_q      <= '0;
            resp_q     <= '0;
            frm_snt_q  <= 1'b0;
            resp_rdy_q <= 1'b0;
            resp_tmo_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            tx_sr_q    <= tx_sr_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            tmo_q      <= tmo_d;
            resp_q     <= resp_d;
            frm_snt_q  <= frm_snt_d;
            resp_rdy_q <= resp_rdy_d;
            resp_tmo_q <= resp_tmo_d;
        end
    end

    // Next-state: frame sequencing, bit timing, response capture and timeout.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        tx_sr_d    = tx_sr_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        resp_cnt_d = resp_cnt_q;
        tmo_d      = tmo_q;
        resp_d     = resp_q;
        frm_snt_d  = frm_snt_q;
        resp_rdy_d = resp_rdy_q;
        resp_tmo_d = resp_tmo_q;

        // Clear first so a set below in the same cycle takes priority.
        if (clr_resp_rdy) begin
            resp_rdy_d = 1'b0;
            resp_tmo_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (snd_cmd) begin
                    frame_d    = {cmd, data};
                    frm_snt_d  = 1'b0;
                    resp_rdy_d = 1'b0;
                    resp_tmo_d = 1'b0;
                    byte_cnt_d = '0;
                    resp_cnt_d = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                tx_sr_d    = {1'b1, frame_q[FW-1 -: 8], 1'b0};
                frame_d    = frame_q << 8;
                baud_d     = '0;
                bit_d      = '0;
                byte_cnt_d = byte_cnt_q + 3'd1;
                state_d    = StTxByte;
            end
            StTxByte: begin
                baud_d = baud_q + 1'b1;
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    tx_sr_d = {1'b1, tx_sr_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                end
                if (bit_q == 4'd9) begin
                    // Between bytes the LOAD cycle supplies the last stop-bit
                    // cycle, so leave one cycle early and keep bytes back to back.
                    if (byte_cnt_q != BYTES_ALL && baud_q == BIT_PRELOAD) begin
                        state_d = StLoad;
                    end else if (byte_cnt_q == BYTES_ALL && baud_q == BIT_LAST) begin
                        frm_snt_d  = 1'b1;
                        byte_cnt_d = '0;
                        tmo_d      = '0;
                        state_d    = StRespWait;
                    end
                end
            end
            StRespWait: begin
                if (rx_vld) begin
                    resp_d     = resp_ext[RW-1:0];
                    resp_cnt_d = resp_cnt_q + 3'd1;
                    tmo_d      = '0;
                    if (resp_cnt_q == RESP_LAST) begin
                        resp_rdy_d = 1'b1;
                        state_d    = StDone;
                    end
                end else if (!rx_busy) begin
                    // Timer is frozen while a byte is arriving.
                    if (tmo_q == TMO_LAST) begin
                        resp_tmo_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign TX       = (state_q == StTxByte) ? tx_sr_q[0] : 1'b1;
    assign frm_snt  = frm_snt_q;
    assign resp_rdy = resp_rdy_q;
    assign resp     = resp_q;
    assign resp_tmo = resp_tmo_q;
    assign busy     = (state_q != StIdle);

endmodule
